wb_write_queue: RTL and testbench
=================================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-002 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-003 The block SHALL have parameter ADDR_W, default 3, register index width.
REQ-004 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port ld_valid  input  1  load result offered by memory stage.
REQ-007 The block SHALL have port ld_rd  input  ADDR_W  load destination register.
REQ-008 The block SHALL have port ld_data  input  DATA_W  load result value.
REQ-009 The block SHALL have port ld_ready  output  1  load result accepted this cycle when high with ld_valid.
REQ-010 The block SHALL have port alu_valid  input  1  ALU result offered by memory stage.
REQ-011 The block SHALL have port alu_rd  input  ADDR_W  ALU destination register.
REQ-012 The block SHALL have port alu_data  input  DATA_W  ALU result value.
REQ-013 The block SHALL have port alu_ready  output  1  ALU result accepted this cycle when high with alu_valid.
REQ-014 The block SHALL have port rf_we  output  1  register-file write enable.
REQ-015 The block SHALL have port rf_waddr  output  ADDR_W  register-file write index.
REQ-016 The block SHALL have port rf_wdata  output  DATA_W  register-file write data.
REQ-017 The block SHALL have port byp_addr  input  ADDR_W  decode-stage source register to look up.
REQ-018 The block SHALL have port byp_hit  output  1  pending write to byp_addr exists.
REQ-019 The block SHALL have port byp_data  output  DATA_W  value of youngest pending write to byp_addr.
REQ-020 The block SHALL have port count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-021 The block SHALL hold pending writes in a circular FIFO with head/tail pointers modulo DEPTH and an occupancy counter.
REQ-022 ld_ready SHALL be high iff count < DEPTH (registered count only; same-cycle pop not credited).
REQ-023 alu_ready SHALL be high iff count + (ld_valid ? 1 : 0) < DEPTH.
REQ-024 A transfer SHALL occur on a port when its valid and ready are both high at a rising clk edge.
REQ-025 When both ports transfer in one cycle, the load entry SHALL be enqueued ahead of the ALU entry (load is the older instruction).
REQ-026 A transfer with destination index 0 SHALL complete the handshake but SHALL NOT be enqueued (r0 is constant zero).
REQ-027 rf_we SHALL be high whenever count > 0, with rf_waddr/rf_wdata equal to the head entry; the head SHALL be popped at every rising edge where rf_we is high.
REQ-028 rf_waddr and rf_wdata SHALL be all-zero when count = 0.
REQ-029 Latency from transfer into an empty queue to rf_we high SHALL be exactly one cycle; one entry retires per cycle thereafter.
REQ-030 Next count SHALL equal count + pushes - pop (pushes in 0..2, pop in 0..1) and SHALL never exceed DEPTH or underflow.
REQ-031 byp_hit SHALL be high iff byp_addr != 0 and at least one queued entry has that index; byp_data SHALL be the youngest such entry's data, else zero.
REQ-032 byp_hit/byp_data SHALL be combinational from queue contents and byp_addr; same-cycle incoming results SHALL NOT be considered.
REQ-033 The head entry SHALL be included in the bypass lookup in the cycle it is written to the register file.

Reset
REQ-034 Asserting rst SHALL immediately clear pointers and count, discarding all pending entries, including mid-drain.
REQ-035 During and after reset, until a transfer: rf_we=0, rf_waddr=0, rf_wdata=0, byp_hit=0, byp_data=0, count=0, ld_ready=1, alu_ready=1.
REQ-036 Entry storage SHALL NOT require reset.

Verification
REQ-037 Single push: ld_valid=1, ld_rd=5, ld_data=0x1234 one cycle -> next cycle rf_we=1, waddr=5, wdata=0x1234; following cycle rf_we=0, count=0.
REQ-038 Dual push ordering: ld(rd=2,0xAAAA) and alu(rd=3,0x5555) same cycle -> rf writes r2=0xAAAA then r3=0x5555 on consecutive cycles.
REQ-039 Full/backpressure: DEPTH=4, count=3, both valid -> ld accepted, alu_ready=0; count=4 -> ld_ready=0 and alu_ready=0 until a pop.
REQ-040 r0 discard: alu_valid=1, alu_rd=0, alu_data=0xFFFF -> alu_ready=1, count stays 0, rf_we stays 0.
REQ-041 Bypass youngest: queue holds r4=0x0001 then r4=0x0002, byp_addr=4 -> byp_hit=1, byp_data=0x0002; byp_addr=0 -> byp_hit=0.
REQ-042 Reset mid-drain: count=3, assert rst asynchronously -> rf_we=0 and count=0 without waiting for a clk edge; no further writes after release.

Source files
------------

// File: rtl/wb_write_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_write_queue_if : result-offer, register-file write and bypass bundle   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface wb_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] byp_addr;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic [c_CNT_W-1:0] count;

  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, byp_addr,
    input  ld_ready, alu_ready, rf_we, rf_waddr, rf_wdata, byp_hit, byp_data, count
  );

  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, byp_addr,
    output ld_ready, alu_ready, rf_we, rf_waddr, rf_wdata, byp_hit, byp_data, count
  );
endinterface
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_write_queue : write-back FIFO merging load/ALU results, with bypass    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  wb_write_queue_if.slave   bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [c_PTR_W-1:0] head_q, head_d;
  logic [c_PTR_W-1:0] tail_q, tail_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic               w_ld_ready, w_alu_ready;
  logic               w_ld_push, w_alu_push, w_pop;
  logic [c_PTR_W-1:0] w_alu_slot;

  // ALU readiness reserves a slot for an offered load even if it is to r0
  assign w_ld_ready  = count_q < c_CNT_W'(DEPTH);
  assign w_alu_ready = ({1'b0, count_q} + (c_CNT_W+1)'(bus.ld_valid)) < (c_CNT_W+1)'(DEPTH);

  assign w_ld_push  = bus.ld_valid  && w_ld_ready  && (bus.ld_rd  != '0);
  assign w_alu_push = bus.alu_valid && w_alu_ready && (bus.alu_rd != '0);
  assign w_pop      = count_q != '0;
  assign w_alu_slot = tail_q + c_PTR_W'(w_ld_push);

  assign head_d  = head_q + c_PTR_W'(w_pop);
  assign tail_d  = tail_q + c_PTR_W'(w_ld_push) + c_PTR_W'(w_alu_push);
  assign count_d = count_q + c_CNT_W'(w_ld_push) + c_CNT_W'(w_alu_push) - c_CNT_W'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_push) begin
      rd_q[tail_q]   <= bus.ld_rd;
      data_q[tail_q] <= bus.ld_data;
    end
    if (w_alu_push) begin
      rd_q[w_alu_slot]   <= bus.alu_rd;
      data_q[w_alu_slot] <= bus.alu_data;
    end
  end

  logic              w_byp_hit;
  logic [DATA_W-1:0] w_byp_data;
  logic [c_PTR_W-1:0] w_idx;

  // Scan oldest to youngest so the last match is the youngest pending write
  always_comb begin
    w_byp_hit  = 1'b0;
    w_byp_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = head_q + c_PTR_W'(i);
      if ((c_CNT_W'(i) < count_q) && (bus.byp_addr != '0) && (rd_q[w_idx] == bus.byp_addr)) begin
        w_byp_hit  = 1'b1;
        w_byp_data = data_q[w_idx];
      end
    end
  end

  assign bus.ld_ready  = w_ld_ready;
  assign bus.alu_ready = w_alu_ready;
  assign bus.rf_we     = w_pop;
  assign bus.rf_waddr  = w_pop ? rd_q[head_q]   : '0;
  assign bus.rf_wdata  = w_pop ? data_q[head_q] : '0;
  assign bus.byp_hit   = w_byp_hit;
  assign bus.byp_data  = w_byp_data;
  assign bus.count     = count_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_write_queue : directed + random bench against a queue model         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_wb_write_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  ent_t mq[$];

  wb_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare every output with the model, then
  // advance the model across the coming rising edge.
  task automatic step(input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldat,
                      input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat,
                      input logic [ADDR_W-1:0] ba);
    int n;
    logic el, ea, eh;
    logic [DATA_W-1:0] ebd;
    logic [ADDR_W-1:0] ewa;
    logic [DATA_W-1:0] ewd;
    @(negedge clk);
    bus.ld_valid  = lv;  bus.ld_rd  = lrd; bus.ld_data  = ldat;
    bus.alu_valid = av;  bus.alu_rd = ard; bus.alu_data = adat;
    bus.byp_addr  = ba;
    #1;
    n  = mq.size();
    el = (n < DEPTH);
    ea = ((n + int'(lv)) < DEPTH);
    eh = 1'b0; ebd = '0; ewa = '0; ewd = '0;
    if (ba != '0)
      for (int i = 0; i < n; i++)
        if (mq[i].rd == ba) begin eh = 1'b1; ebd = mq[i].data; end
    if (n > 0) begin ewa = mq[0].rd; ewd = mq[0].data; end
    check("count",     32'(bus.count),     32'(n));
    check("ld_ready",  32'(bus.ld_ready),  32'(el));
    check("alu_ready", 32'(bus.alu_ready), 32'(ea));
    check("rf_we",     32'(bus.rf_we),     32'(n > 0));
    check("rf_waddr",  32'(bus.rf_waddr),  32'(ewa));
    check("rf_wdata",  32'(bus.rf_wdata),  32'(ewd));
    check("byp_hit",   32'(bus.byp_hit),   32'(eh));
    check("byp_data",  32'(bus.byp_data),  32'(ebd));
    if (n > 0) void'(mq.pop_front());
    if (lv && el && lrd != '0) mq.push_back('{rd: lrd, data: ldat});
    if (av && ea && ard != '0) mq.push_back('{rd: ard, data: adat});
  endtask

  task automatic idle(input logic [ADDR_W-1:0] ba);
    step(1'b0, '0, '0, 1'b0, '0, '0, ba);
  endtask

  initial begin
    bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.byp_addr = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_rf_we",     32'(bus.rf_we),     32'd0);
    check("rst_ld_ready",  32'(bus.ld_ready),  32'd1);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("rst_byp_hit",   32'(bus.byp_hit),   32'd0);
    rst = 1'b0;

    // Single push then drain
    step(1'b1, 3'd5, 16'h1234, 1'b0, '0, '0, 3'd5);
    step(1'b0, '0, '0, 1'b0, '0, '0, 3'd5);
    check("single_waddr", 32'(bus.rf_waddr), 32'd5);
    check("single_wdata", 32'(bus.rf_wdata), 32'h1234);
    check("single_bypass_head", 32'(bus.byp_data), 32'h1234);
    idle(3'd5);
    check("single_done", 32'(bus.rf_we), 32'd0);

    // Dual push ordering
    step(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd3, 16'h5555, 3'd0);
    idle(3'd0);
    check("dual_first", 32'(bus.rf_waddr), 32'd2);
    idle(3'd0);
    check("dual_second", 32'(bus.rf_wdata), 32'h5555);
    idle(3'd0);

    // r0 discard
    step(1'b0, '0, '0, 1'b1, 3'd0, 16'hFFFF, 3'd0);
    check("r0_ready", 32'(bus.alu_ready), 32'd1);
    idle(3'd0);
    check("r0_count", 32'(bus.count), 32'd0);

    // Bypass youngest, then backpressure at count 3
    step(1'b1, 3'd4, 16'h0001, 1'b1, 3'd4, 16'h0002, 3'd4);
    step(1'b1, 3'd6, 16'h0066, 1'b1, 3'd7, 16'h0077, 3'd4);
    check("byp_youngest", 32'(bus.byp_data), 32'h0002);
    step(1'b1, 3'd1, 16'h0011, 1'b1, 3'd1, 16'h0022, 3'd0);
    check("full_ld_ready",  32'(bus.ld_ready),  32'd1);
    check("full_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("full_byp_r0",    32'(bus.byp_hit),   32'd0);

    // Asynchronous reset mid-drain
    @(negedge clk);
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0; bus.byp_addr = 3'd1;
    #1;
    check("pre_rst_count", 32'(bus.count), 32'd3);
    rst = 1'b1;
    #1;
    check("async_rf_we", 32'(bus.rf_we),   32'd0);
    check("async_count", 32'(bus.count),   32'd0);
    check("async_byp",   32'(bus.byp_hit), 32'd0);
    mq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) idle(3'd1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
           ($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
           ADDR_W'($urandom_range(0, 7)));
    end
    repeat (6) idle(3'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
